// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// RISCV_FETCH_MISALIGN_EN (optional) enables the FAULT state and instr_misalign output.
package riscv_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} entries; pointers wrap modulo DEPTH (power of two).
// A flush together with a push leaves exactly the pushed entry in the FIFO.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            pop_ok;
    logic            push_ok;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(push);
            cnt    <= (AW+1)'(push);
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            if (push) mem[0] <= push_data;
        end else if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: one outstanding req/ack fetch feeding a prefetch FIFO.
// Define RISCV_FETCH_MISALIGN_EN to trap misaligned redirect targets into FAULT.
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
`ifdef RISCV_FETCH_MISALIGN_EN
    output logic            instr_misalign,
`endif
    input  logic            instr_ready
);

    fetch_state_t           state;
    logic [XLEN-1:0]        fetch_pc;
    logic [XLEN-1:0]        target_pc;
    logic                   bad_target;
    logic                   fifo_push;
    logic                   fifo_pop;
    fetch_entry_t           fifo_wdata;
    fetch_entry_t           fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   unused_count;

`ifdef RISCV_FETCH_MISALIGN_EN
    logic misalign_q;
    assign target_pc      = redirect_pc;
    assign bad_target     = redirect & (redirect_pc[1:0] != 2'b00);
    assign instr_misalign = misalign_q & instr_valid;
`else
    assign target_pc  = redirect_pc & ~32'h3;
    assign bad_target = 1'b0;
`endif

    assign unused_count = ^fifo_count;
    assign instr_valid  = ~fifo_empty;
    assign instr        = instr_valid ? fifo_head.instr : '0;
    assign instr_pc     = instr_valid ? fifo_head.pc    : '0;
    assign fifo_pop     = instr_valid & instr_ready & ~redirect;

    // A misaligned redirect flushes and pushes the NOP marker in the same edge.
    always_comb begin
        fifo_push  = 1'b0;
        fifo_wdata = '{pc: mem_addr, instr: mem_rdata};
        if (redirect) begin
            if (bad_target) begin
                fifo_push  = 1'b1;
                fifo_wdata = '{pc: target_pc, instr: NOP_INSTR};
            end
        end else if (state == WAIT && mem_ack) begin
            fifo_push = 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .flush     (redirect),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
`ifdef RISCV_FETCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else if (redirect) begin
            fetch_pc <= target_pc;
`ifdef RISCV_FETCH_MISALIGN_EN
            misalign_q <= bad_target;
`endif
            if (mem_req && mem_ack) mem_req <= 1'b0;
            // An unacked request stays on the bus; FAULT or DISCARD absorbs its ack.
            if (bad_target)               state <= FAULT;
            else if (mem_req && !mem_ack) state <= DISCARD;
            else                          state <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (!fifo_full) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        fetch_pc <= fetch_pc + PC_STEP;
                        state    <= FETCH;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= FETCH;
                    end
                end
                default: begin
                    if (mem_ack) mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit with a latency-programmable memory responder.
// Builds with or without RISCV_FETCH_MISALIGN_EN.
module tb_riscv_fetch_unit;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef RISCV_FETCH_MISALIGN_EN
    logic        instr_misalign;
`endif

    int tests = 0;
    int fails = 0;
    int lat   = 1;
    int ack_cnt = 0;

    riscv_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
`ifdef RISCV_FETCH_MISALIGN_EN
        .instr_misalign (instr_misalign),
`endif
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    // Memory: ack in the lat-th cycle that mem_req is seen high; data = addr ^ KEY.
    always @(negedge clk) begin
        if (!rst || !mem_req) begin
            ack_cnt = 0;
            mem_ack = 1'b0;
        end else begin
            ack_cnt = ack_cnt + 1;
            mem_ack = (ack_cnt == lat);
            mem_rdata = mem_addr ^ KEY;
        end
    end

    task automatic do_reset(input logic rdy, input int l);
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = rdy;
        lat = l;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h pc=%h, required 0/0/0/0/0",
                     mem_req, mem_addr, instr_valid, instr, instr_pc);
        end
        lat = 3;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL first_req: req=%b addr=%h, required 1/00000000", mem_req, mem_addr);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: req=%b addr=%h, required 0/00000000", mem_req, mem_addr);
        end
    endtask

    task automatic test_basic;
        int got = 0;
        int last_c = 0;
        logic [31:0] exp = 32'h0;
        do_reset(1'b1, 1);
        for (int c = 1; c <= 30 && got < 3; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                tests++;
                if (instr_pc !== exp || instr !== (exp ^ KEY)) begin
                    fails++;
                    $display("FAIL basic_order: pc=%h instr=%h, required %h/%h",
                             instr_pc, instr, exp, exp ^ KEY);
                end
                if (got > 0) begin
                    tests++;
                    if (c - last_c != 2) begin
                        fails++;
                        $display("FAIL basic_rate: gap=%0d cycles, required 2", c - last_c);
                    end
                end
                last_c = c;
                exp = exp + 32'd4;
                got++;
            end
        end
        tests++;
        if (got != 3) begin
            fails++;
            $display("FAIL basic_timeout: got %0d instructions, required 3", got);
        end
    endtask

    task automatic test_fill;
        logic [31:0] issued [8];
        int n = 0;
        logic prev = 1'b0;
        do_reset(1'b0, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req && !prev && n < 8) begin
                issued[n] = mem_addr;
                n++;
            end
            prev = mem_req;
        end
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL fill_count: issued %0d requests, required 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            tests++;
            if (issued[i] !== 32'(i * 4)) begin
                fails++;
                $display("FAIL fill_addr%0d: addr=%h, required %h", i, issued[i], 32'(i * 4));
            end
        end
        tests++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL fill_hold: req=%b valid=%b pc=%h, required 0/1/00000000",
                     mem_req, instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        tests++;
        if (instr_pc !== 32'h4 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL fill_pop: pc=%h req=%b, required 00000004/0", instr_pc, mem_req);
        end
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            fails++;
            $display("FAIL fill_resume: req=%b addr=%h, required 1/00000010", mem_req, mem_addr);
        end
    endtask

    // Continues from test_fill: FIFO holds 4,8,C and the 0x10 request acks now.
    task automatic test_pop_push;
        logic [31:0] exp = 32'h8;
        int got = 0;
        instr_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin
            fails++;
            $display("FAIL popush_head: valid=%b pc=%h, required 1/00000008", instr_valid, instr_pc);
        end
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (instr_valid) begin
                tests++;
                if (instr_pc !== exp || instr !== (exp ^ KEY)) begin
                    fails++;
                    $display("FAIL popush_order: pc=%h instr=%h, required %h/%h",
                             instr_pc, instr, exp, exp ^ KEY);
                end
                exp = exp + 32'd4;
                got++;
            end
            @(negedge clk);
        end
        tests++;
        if (got != 4) begin
            fails++;
            $display("FAIL popush_timeout: got %0d, required 4", got);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_wait;
        logic prev = 1'b1;
        logic seen = 1'b0;
        logic got = 1'b0;
        logic stale = 1'b0;
        logic [31:0] first_addr = '0;
        logic [31:0] got_pc = '0;
        do_reset(1'b1, 3);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL rdw_hold: req=%b addr=%h, required 1/00000000", mem_req, mem_addr);
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (mem_req && !prev && !seen) begin
                first_addr = mem_addr;
                seen = 1'b1;
            end
            prev = mem_req;
            if (instr_valid) begin
                if (instr_pc !== 32'h100) stale = 1'b1;
                got_pc = instr_pc;
                got = 1'b1;
            end
        end
        tests++;
        if (!seen || first_addr !== 32'h100) begin
            fails++;
            $display("FAIL rdw_addr: seen=%b addr=%h, required 1/00000100", seen, first_addr);
        end
        tests++;
        if (!got || stale || got_pc !== 32'h100) begin
            fails++;
            $display("FAIL rdw_data: got=%b stale=%b pc=%h, required 1/0/00000100", got, stale, got_pc);
        end
    endtask

    task automatic test_redirect_ack_pop;
        logic found = 1'b0;
        do_reset(1'b0, 1);
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h4) found = 1'b1;
        end
        tests++;
        if (!found || instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL rap_setup: found=%b valid=%b, required 1/1", found, instr_valid);
        end
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        instr_ready = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL rap_flush: valid=%b req=%b, required 0/0", instr_valid, mem_req);
        end
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            fails++;
            $display("FAIL rap_refetch: req=%b addr=%h, required 1/00000200", mem_req, mem_addr);
        end
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== (32'h200 ^ KEY)) begin
            fails++;
            $display("FAIL rap_data: valid=%b pc=%h instr=%h, required 1/00000200/%h",
                     instr_valid, instr_pc, instr, 32'h200 ^ KEY);
        end
    endtask

    task automatic test_wrap;
        do_reset(1'b1, 1);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        tests++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_drop: valid=%b, required 0", instr_valid);
        end
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL wrap_top: req=%b addr=%h, required 1/fffffffc", mem_req, mem_addr);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL wrap_zero: req=%b addr=%h, required 1/00000000", mem_req, mem_addr);
        end
    endtask

`ifdef RISCV_FETCH_MISALIGN_EN
    task automatic test_misalign;
        logic saw_req = 1'b0;
        do_reset(1'b0, 1);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h102 || instr !== 32'h13 ||
            instr_misalign !== 1'b1) begin
            fails++;
            $display("FAIL fault_entry: valid=%b pc=%h instr=%h mis=%b, required 1/00000102/00000013/1",
                     instr_valid, instr_pc, instr, instr_misalign);
        end
        for (int c = 0; c < 6; c++) begin
            if (mem_req) saw_req = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (saw_req || instr_pc !== 32'h102) begin
            fails++;
            $display("FAIL fault_idle: saw_req=%b pc=%h, required 0/00000102", saw_req, instr_pc);
        end
        redirect = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || instr_misalign !== 1'b0) begin
            fails++;
            $display("FAIL fault_exit: valid=%b mis=%b, required 0/0", instr_valid, instr_misalign);
        end
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            fails++;
            $display("FAIL fault_resume: req=%b addr=%h, required 1/00000300", mem_req, mem_addr);
        end
    endtask
`else
    task automatic test_align;
        do_reset(1'b1, 1);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            fails++;
            $display("FAIL align_addr: req=%b addr=%h, required 1/00000100", mem_req, mem_addr);
        end
        @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            fails++;
            $display("FAIL align_pc: valid=%b pc=%h, required 1/00000100", instr_valid, instr_pc);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_fill;
        test_pop_push;
        test_redirect_wait;
        test_redirect_ack_pop;
        test_wrap;
`ifdef RISCV_FETCH_MISALIGN_EN
        test_misalign;
`else
        test_align;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle core's decode/execute datapath.
- Issues word fetches to instruction memory over a req/ack handshake.
- Buffers {pc, instr} pairs in a small prefetch FIFO and hands them to the core over valid/ready.
- Core redirects (taken branch/jump target) flush the buffer and restart fetch at the new PC.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- mem_req  output  1  fetch request to instruction memory; registered.
- mem_addr  output  32  fetch address; registered; stable while mem_req=1.
- mem_ack  input  1  memory response valid; may assert 1..N cycles after mem_req.
- mem_rdata  input  32  instruction word; valid when mem_ack=1.
- redirect  input  1  core requests a fetch restart (pcsrc taken).
- redirect_pc  input  32  restart address; sampled when redirect=1.
- instr_valid  output  1  FIFO head is valid.
- instr  output  32  instruction at FIFO head; 32'h0 when empty.
- instr_pc  output  32  PC of the FIFO head instruction; 32'h0 when empty.
- instr_ready  input  1  core consumes the head when instr_valid & instr_ready.

Behaviour:
- Reset values (async assert, sync release): mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO empty, instr_valid=0, instr=0, instr_pc=0, state=FETCH.
- At most one outstanding memory request.
- FSM states:
  - FETCH: if count < DEPTH and no redirect, set mem_req=1 and mem_addr=fetch_pc next cycle; go to WAIT. Otherwise stay.
  - WAIT: hold mem_req and mem_addr until mem_ack. On ack without redirect: push {mem_addr, mem_rdata}, fetch_pc += 4 (mod 2^32 wrap), mem_req=0, go to FETCH.
  - DISCARD: hold mem_req until mem_ack. On ack: drop the data, mem_req=0, go to FETCH. fetch_pc already holds the redirect target.
- A request is never issued unless a free slot exists, so a push can never overflow the FIFO.
- An issued request is never withdrawn before ack.
- Pop: on instr_valid & instr_ready, the head advances. A pop and a push in the same cycle are both honoured; count is unchanged.
- Redirect (highest priority, any state):
  - FIFO flushed, so instr_valid=0 next cycle.
  - A same-cycle pop is ignored.
  - fetch_pc=redirect_pc.
  - FETCH stays FETCH; WAIT without ack goes to DISCARD; WAIT with same-cycle ack drops the data and goes to FETCH.
  - Redirect while in DISCARD only updates fetch_pc.
- Latency:
  - mem_req rises on the first clock edge after rst release.
  - mem_ack in cycle N gives instr_valid=1 in cycle N+1.
  - With a 1-cycle memory, steady-state throughput is one instruction per 2 cycles.
- The FIFO pointers wrap modulo DEPTH. Count is DEPTH when full and 0 when empty.
- Reset asserted mid-transaction abandons the outstanding request; the memory must tolerate a dropped ack.

Optional Feature:
- Macro: RISCV_FETCH_MISALIGN_EN.
- Defined:
  - Adds output instr_misalign (1 bit, reset 0).
  - A redirect_pc with bits [1:0] != 0 is not fetched.
  - The FSM enters FAULT: no requests, and one FIFO entry is pushed with instr=32'h0000_0013 (NOP), instr_pc=redirect_pc, instr_misalign=1.
  - FAULT exits only on the next redirect.
- Undefined: redirect_pc[1:0] is forced to 2'b00; there is no extra port and no FAULT state.

Decomposition:
- Package riscv_fetch_pkg:
  - fetch_state_t enum {FETCH, WAIT, DISCARD, FAULT}.
  - XLEN=32.
  - PC_STEP=4.
  - NOP_INSTR=32'h0000_0013.
  - fetch_entry_t struct {pc, instr}.
- Sub-module fetch_fifo: a parameterised synchronous FIFO with push, pop, flush, full, empty, count and head outputs. It is instantiated once by riscv_fetch_unit.

Test Plan:
- Reset release, 1-cycle ack memory, instr_ready=1 → fetch addresses 0x0, 0x4, 0x8 in order; instr_pc matches each address; instr_valid pulses every 2nd cycle.
- instr_ready=0 held → exactly DEPTH=4 entries fetched (0x0–0xC); mem_req stays 0 until the first pop.
- Redirect to 0x100 while in WAIT with ack 3 cycles later → acked data dropped; next mem_addr=0x100; no stale instr_valid.
- Redirect to 0x200 in the same cycle as mem_ack and a pop → FIFO empty next cycle; next fetch at 0x200.
- Full FIFO, simultaneous pop and push → count stays DEPTH; order preserved; no overflow.
- With macro, redirect to 0x102 → one entry {0x102, NOP}, instr_misalign=1, no mem_req; redirect to 0x300 resumes fetch.
